// File: rtl/dpot_spi_ctrl.sv
// ---------------------------------------------------------------------------
// dpot_spi_ctrl
//
// SPI serializer for the three digital potentiometers on the WAC board.
// One pot word plus a pot select is accepted through a valid/ready handshake.
// The word is shifted out MSB first in SPI mode 0 on the shared
// clkDpot/sdiDpot lines while only the selected pot's chip select is low.
// Completion is reported with a one-cycle doneStb. A command that names the
// nonexistent fourth pot is dropped and flagged with a one-cycle errSel.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     synchronous reset, active-low
//   cmdValid  command present
//   cmdReady  block can accept a command (high only in IDLE)
//   cmdSel    target pot: 0 -> csDpot1, 1 -> csDpot2, 2 -> csDpot3, 3 illegal
//   cmdData   word to shift out, MSB first
//   busy      transaction in progress
//   doneStb   one-cycle pulse in the first IDLE cycle after a transaction
//   errSel    one-cycle pulse when a cmdSel=3 command is dropped
//   csDpot1..3  chip selects, active-low
//   sdiDpot   serial data to the pots
//   clkDpot   SPI clock, idle low, pots sample on the rising edge
//
// Parameters:
//   CLK_DIV   clk cycles per SPI half-period (>= 1)
//   DATA_W    bits per pot word (>= 2)
// ---------------------------------------------------------------------------
module dpot_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdSel,
  input  logic [DATA_W-1:0] cmdData,
  output logic              busy,
  output logic              doneStb,
  output logic              errSel,
  output logic              csDpot1,
  output logic              csDpot2,
  output logic              csDpot3,
  output logic              sdiDpot,
  output logic              clkDpot
);

  // Parameter sanity checks at elaboration time.
  generate
    if (CLK_DIV < 1) begin : gBadClkDiv
      $error("dpot_spi_ctrl: CLK_DIV must be at least 1");
    end
    if (DATA_W < 2) begin : gBadDataW
      $error("dpot_spi_ctrl: DATA_W must be at least 2");
    end
  endgenerate

  // Counter widths are clamped to 1 bit so CLK_DIV=1 still yields a legal
  // vector; with a single-cycle phase the counter simply stays at zero.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } stateT;

  stateT             state;
  logic [DIV_W-1:0]  divCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shiftReg;
  logic              phaseEnd;

  // Handshake and status are pure decodes of the registered state, so
  // cmdReady is already high in the cycle that carries doneStb and a
  // back-to-back command can be taken there.
  assign cmdReady = (state == IDLE);
  assign busy     = (state != IDLE);
  assign phaseEnd = (divCnt == DIV_LAST);

  // Single sequencer: every phase lasts CLK_DIV cycles. All pin outputs are
  // assigned here so they come straight from flops. shiftReg keeps the
  // current bit in its MSB; sdiDpot is loaded from the next bit down on
  // entry to LOW so data only moves while clkDpot is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      divCnt   <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      csDpot1  <= 1'b1;
      csDpot2  <= 1'b1;
      csDpot3  <= 1'b1;
      sdiDpot  <= 1'b0;
      clkDpot  <= 1'b0;
      doneStb  <= 1'b0;
      errSel   <= 1'b0;
    end else begin
      doneStb <= 1'b0;
      errSel  <= 1'b0;

      if (state != IDLE) begin
        divCnt <= phaseEnd ? '0 : divCnt + 1'b1;
      end

      case (state)
        IDLE: begin
          divCnt <= '0;
          bitCnt <= '0;
          if (cmdValid) begin
            if (cmdSel == 2'd3) begin
              errSel <= 1'b1;
            end else begin
              state    <= SETUP;
              shiftReg <= cmdData;
              sdiDpot  <= cmdData[DATA_W-1];
              clkDpot  <= 1'b0;
              csDpot1  <= (cmdSel != 2'd0);
              csDpot2  <= (cmdSel != 2'd1);
              csDpot3  <= (cmdSel != 2'd2);
            end
          end
        end

        SETUP: begin
          if (phaseEnd) begin
            state   <= HIGH;
            clkDpot <= 1'b1;
          end
        end

        // The last HIGH goes to HOLD rather than LOW so sdiDpot keeps the
        // LSB until CS is released.
        HIGH: begin
          if (phaseEnd) begin
            clkDpot <= 1'b0;
            if (bitCnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              state    <= LOW;
              bitCnt   <= bitCnt + 1'b1;
              shiftReg <= shiftReg << 1;
              sdiDpot  <= shiftReg[DATA_W-2];
            end
          end
        end

        LOW: begin
          if (phaseEnd) begin
            state   <= HIGH;
            clkDpot <= 1'b1;
          end
        end

        HOLD: begin
          if (phaseEnd) begin
            state   <= GAP;
            csDpot1 <= 1'b1;
            csDpot2 <= 1'b1;
            csDpot3 <= 1'b1;
            sdiDpot <= 1'b0;
          end
        end

        // GAP keeps every CS high for a full phase, which is what makes an
        // immediate back-to-back command safe.
        GAP: begin
          if (phaseEnd) begin
            state    <= IDLE;
            doneStb  <= 1'b1;
            bitCnt   <= '0;
            shiftReg <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          csDpot1 <= 1'b1;
          csDpot2 <= 1'b1;
          csDpot3 <= 1'b1;
          sdiDpot <= 1'b0;
          clkDpot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpot_spi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dpot_spi_ctrl
//
// Directed bench for dpot_spi_ctrl. Two instances share clk and rst_n: a
// default CLK_DIV=4 build ("Slow") and a CLK_DIV=1 build ("Fast"). Pins are
// sampled 1 time unit after each rising edge; sample k of a transaction is
// the cycle t0+k where t0 is the accept edge.
// ---------------------------------------------------------------------------
module tb_dpot_spi_ctrl;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic err;
    logic cs1;
    logic cs2;
    logic cs3;
    logic sdi;
    logic sclk;
  } pinsT;

  // Idle pin pattern: ready=1, busy/done/err=0, all CS high, sdi=0, sclk=0.
  localparam logic [31:0] IDLE_PINS = 32'h11C;

  logic        clk;
  logic        rst_n;

  logic        cmdValidSlow, cmdValidFast;
  logic [1:0]  cmdSelSlow, cmdSelFast;
  logic [15:0] cmdDataSlow, cmdDataFast;
  logic        readySlow, busySlow, doneSlow, errSlow;
  logic        cs1Slow, cs2Slow, cs3Slow, sdiSlow, sclkSlow;
  logic        readyFast, busyFast, doneFast, errFast;
  logic        cs1Fast, cs2Fast, cs3Fast, sdiFast, sclkFast;

  pinsT pinsSlow, pinsFast;
  assign pinsSlow = {readySlow, busySlow, doneSlow, errSlow,
                     cs1Slow, cs2Slow, cs3Slow, sdiSlow, sclkSlow};
  assign pinsFast = {readyFast, busyFast, doneFast, errFast,
                     cs1Fast, cs2Fast, cs3Fast, sdiFast, sclkFast};

  int checks   = 0;
  int failures = 0;

  int          obsRise, obsBusy, obsBusyFirst, obsBusyLast;
  int          obsDoneAt, obsDoneCnt, obsErrAt, obsErrCnt, obsReady;
  int          obsClkHigh, obsBadSdi, obsFirstCsLow;
  int          obsCsLow1, obsCsLow2, obsCsLow3, obsCs1Last;
  logic [15:0] obsWord;
  pinsT        obsLast;
  int          cs1LastFirst;
  int          csGap;

  dpot_spi_ctrl uDutSlow (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmdValid (cmdValidSlow),
    .cmdReady (readySlow),
    .cmdSel   (cmdSelSlow),
    .cmdData  (cmdDataSlow),
    .busy     (busySlow),
    .doneStb  (doneSlow),
    .errSel   (errSlow),
    .csDpot1  (cs1Slow),
    .csDpot2  (cs2Slow),
    .csDpot3  (cs3Slow),
    .sdiDpot  (sdiSlow),
    .clkDpot  (sclkSlow)
  );

  dpot_spi_ctrl #(.CLK_DIV(1), .DATA_W(16)) uDutFast (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmdValid (cmdValidFast),
    .cmdReady (readyFast),
    .cmdSel   (cmdSelFast),
    .cmdData  (cmdDataFast),
    .busy     (busyFast),
    .doneStb  (doneFast),
    .errSel   (errFast),
    .csDpot1  (cs1Fast),
    .csDpot2  (cs2Fast),
    .csDpot3  (cs3Fast),
    .sdiDpot  (sdiFast),
    .clkDpot  (sclkFast)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one command at the current sample point and returns at sample 1
  // of the transaction (1 time unit after the accept edge).
  task automatic applyStimulus(input bit fast, input logic [1:0] sel,
                               input logic [15:0] data, input bit keepValid,
                               input string tag);
    checkOutput(tag, fast ? 32'(readyFast) : 32'(readySlow), 32'd1);
    if (fast) begin
      cmdValidFast = 1'b1; cmdSelFast = sel; cmdDataFast = data;
    end else begin
      cmdValidSlow = 1'b1; cmdSelSlow = sel; cmdDataSlow = data;
    end
    @(posedge clk); #1;
    if (!keepValid) begin
      if (fast) cmdValidFast = 1'b0;
      else      cmdValidSlow = 1'b0;
    end
  endtask

  // Watches one DUT for up to nCycles samples starting at the current one.
  // Stops early once stopAtRise clkDpot rising edges have been seen (0 = off).
  task automatic observe(input bit fast, input int nCycles, input int stopAtRise);
    pinsT p;
    pinsT prev;
    obsRise = 0; obsBusy = 0; obsBusyFirst = 0; obsBusyLast = 0;
    obsDoneAt = 0; obsDoneCnt = 0; obsErrAt = 0; obsErrCnt = 0; obsReady = 0;
    obsClkHigh = 0; obsBadSdi = 0; obsFirstCsLow = 0;
    obsCsLow1 = 0; obsCsLow2 = 0; obsCsLow3 = 0; obsCs1Last = 0;
    obsWord = '0;
    p = fast ? pinsFast : pinsSlow;
    prev = p;
    for (int k = 1; k <= nCycles; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      p = fast ? pinsFast : pinsSlow;
      if (k > 1 && p.sclk && !prev.sclk) begin
        obsRise++;
        obsWord = {obsWord[14:0], p.sdi};
      end
      if (k > 1 && p.sclk && (p.sdi !== prev.sdi)) obsBadSdi++;
      if (p.sclk) obsClkHigh++;
      if (p.busy) begin
        obsBusy++;
        if (obsBusyFirst == 0) obsBusyFirst = k;
        obsBusyLast = k;
      end
      if (p.done) begin
        obsDoneCnt++;
        if (obsDoneAt == 0) obsDoneAt = k;
      end
      if (p.err) begin
        obsErrCnt++;
        if (obsErrAt == 0) obsErrAt = k;
      end
      if (p.ready) obsReady++;
      if (!p.cs1) begin
        obsCsLow1++;
        obsCs1Last = k;
      end
      if (!p.cs2) obsCsLow2++;
      if (!p.cs3) obsCsLow3++;
      if ((!p.cs1 || !p.cs2 || !p.cs3) && obsFirstCsLow == 0) obsFirstCsLow = k;
      prev = p;
      if (stopAtRise != 0 && obsRise == stopAtRise) break;
    end
    obsLast = p;
  endtask

  initial begin
    rst_n = 1'b0;
    cmdValidSlow = 1'b1; cmdSelSlow = 2'd0; cmdDataSlow = 16'hFFFF;
    cmdValidFast = 1'b1; cmdSelFast = 2'd0; cmdDataFast = 16'hFFFF;

    // Reset held 5 cycles with a command offered: nothing may start.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_pins_slow", 32'(pinsSlow), IDLE_PINS);
    checkOutput("rst_pins_fast", 32'(pinsFast), IDLE_PINS);
    cmdValidSlow = 1'b0;
    cmdValidFast = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_after_release", 32'(pinsSlow), IDLE_PINS);

    // Basic write: pot 2, A55A.
    applyStimulus(1'b0, 2'd1, 16'hA55A, 1'b0, "basic_ready");
    observe(1'b0, 140, 0);
    checkOutput("basic_word",       32'(obsWord), 32'hA55A);
    checkOutput("basic_rises",      obsRise, 16);
    checkOutput("basic_cs2_low",    obsCsLow2, 132);
    checkOutput("basic_cs1_low",    obsCsLow1, 0);
    checkOutput("basic_cs3_low",    obsCsLow3, 0);
    checkOutput("basic_done_at",    obsDoneAt, 137);
    checkOutput("basic_done_cnt",   obsDoneCnt, 1);
    checkOutput("basic_busy_cnt",   obsBusy, 136);
    checkOutput("basic_busy_first", obsBusyFirst, 1);
    checkOutput("basic_busy_last",  obsBusyLast, 136);
    checkOutput("basic_clk_high",   obsClkHigh, 64);
    checkOutput("basic_sdi_stable", obsBadSdi, 0);
    checkOutput("basic_err_cnt",    obsErrCnt, 0);
    checkOutput("basic_end_pins",   32'(obsLast), IDLE_PINS);

    // Illegal select: dropped with a single errSel pulse.
    applyStimulus(1'b0, 2'd3, 16'hFFFF, 1'b0, "illegal_ready");
    observe(1'b0, 200, 0);
    checkOutput("illegal_err_at",  obsErrAt, 1);
    checkOutput("illegal_err_cnt", obsErrCnt, 1);
    checkOutput("illegal_cs_low",  obsCsLow1 + obsCsLow2 + obsCsLow3, 0);
    checkOutput("illegal_clk",     obsClkHigh, 0);
    checkOutput("illegal_ready",   obsReady, 200);
    checkOutput("illegal_busy",    obsBusy, 0);
    checkOutput("illegal_done",    obsDoneCnt, 0);

    // Back-to-back: valid stays high, second command waits for doneStb.
    applyStimulus(1'b0, 2'd0, 16'h0001, 1'b1, "b2b_ready");
    cmdSelSlow  = 2'd2;
    cmdDataSlow = 16'h8000;
    observe(1'b0, 137, 0);
    checkOutput("b2b1_word",    32'(obsWord), 32'h0001);
    checkOutput("b2b1_cs1_low", obsCsLow1, 132);
    checkOutput("b2b1_cs3_low", obsCsLow3, 0);
    checkOutput("b2b1_done_at", obsDoneAt, 137);
    checkOutput("b2b1_ready",   32'(obsLast.ready), 32'd1);
    cs1LastFirst = obsCs1Last;
    @(posedge clk); #1;
    cmdValidSlow = 1'b0;
    observe(1'b0, 140, 0);
    csGap = (137 - cs1LastFirst) + (obsFirstCsLow - 1);
    checkOutput("b2b2_setup_at", obsFirstCsLow, 1);
    checkOutput("b2b_cs_gap_ge4", 32'(csGap >= 4), 32'd1);
    checkOutput("b2b2_word",    32'(obsWord), 32'h8000);
    checkOutput("b2b2_cs3_low", obsCsLow3, 132);
    checkOutput("b2b2_cs1_low", obsCsLow1, 0);
    checkOutput("b2b2_done_at", obsDoneAt, 137);

    // Reset after the 7th clkDpot rise aborts without doneStb.
    applyStimulus(1'b0, 2'd1, 16'hC3A5, 1'b0, "midrst_ready");
    observe(1'b0, 200, 7);
    checkOutput("midrst_rises", obsRise, 7);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_pins", 32'(pinsSlow), IDLE_PINS);
    @(posedge clk); #1;
    checkOutput("midrst_pins_hold", 32'(pinsSlow), IDLE_PINS);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_no_done", 32'(pinsSlow), IDLE_PINS);
    applyStimulus(1'b0, 2'd2, 16'h3C96, 1'b0, "fresh_ready");
    observe(1'b0, 140, 0);
    checkOutput("fresh_word",    32'(obsWord), 32'h3C96);
    checkOutput("fresh_cs3_low", obsCsLow3, 132);
    checkOutput("fresh_done_at", obsDoneAt, 137);

    // CLK_DIV=1 build: 34-cycle transaction.
    applyStimulus(1'b1, 2'd0, 16'h1234, 1'b0, "fast_ready");
    observe(1'b1, 40, 0);
    checkOutput("fast_word",       32'(obsWord), 32'h1234);
    checkOutput("fast_rises",      obsRise, 16);
    checkOutput("fast_clk_high",   obsClkHigh, 16);
    checkOutput("fast_busy_cnt",   obsBusy, 34);
    checkOutput("fast_done_at",    obsDoneAt, 35);
    checkOutput("fast_cs1_low",    obsCsLow1, 33);
    checkOutput("fast_sdi_stable", obsBadSdi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
